// File: rtl/mct_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mct_rd_arbiter
// Purpose  : Merges two AXI4 read requesters onto one shared AXI4 read
//            master. A two-state AR FSM (ARB/ISSUE) picks one requester
//            per burst. An order FIFO holds one requester id per granted,
//            uncompleted burst. R beats are steered to the requester at the
//            FIFO head with no added latency. Bursts complete in issue order
//            because only one AXI ID is used.
//
// Ports    : clk, rst_n                - clock, async active-low reset
//            s0_ar*/s1_ar*             - requester AR channels (slave side)
//            s0_r*/s1_r*               - requester R channels (rdata/rlast
//                                        broadcast to both)
//            m_axi_ar*/m_axi_r*        - shared AXI4 read master
//            outstanding               - order-FIFO occupancy
//            idle                      - FSM in ARB and nothing outstanding
//
// Config   : MCT_RD_ARB_ROUND_ROBIN_EN
//              defined   -> a tie goes to the requester not granted last
//              undefined -> fixed priority, requester 0 wins a tie
//
// Revision : 1.0 - initial release
// ============================================================================
module mct_rd_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_MAX_OUTSTANDING  = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  // requester 0
  input  logic                                   s0_arvalid,
  output logic                                   s0_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]          s0_araddr,
  input  logic [7:0]                             s0_arlen,
  output logic                                   s0_rvalid,
  input  logic                                   s0_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]          s0_rdata,
  output logic                                   s0_rlast,
  // requester 1
  input  logic                                   s1_arvalid,
  output logic                                   s1_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]          s1_araddr,
  input  logic [7:0]                             s1_arlen,
  output logic                                   s1_rvalid,
  input  logic                                   s1_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]          s1_rdata,
  output logic                                   s1_rlast,
  // shared AXI4 read master
  output logic                                   m_axi_arvalid,
  input  logic                                   m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]          m_axi_araddr,
  output logic [7:0]                             m_axi_arlen,
  input  logic                                   m_axi_rvalid,
  output logic                                   m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]          m_axi_rdata,
  input  logic                                   m_axi_rlast,
  // status
  output logic [$clog2(C_MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                   idle
);

  localparam int                 C_PTR_W   = $clog2(C_MAX_OUTSTANDING);
  localparam int                 C_CNT_W   = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [C_CNT_W-1:0] C_MAX_CNT = C_CNT_W'(C_MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_sel;        // requester owning the current ISSUE
  logic                 w_win;        // arbitration result in ARB
  logic                 w_grant;      // ARB -> ISSUE this cycle
  logic                 w_sel_arvalid;
  logic                 w_ar_hs;      // AR handshake on the master side
  logic                 w_pop;        // last beat of the head burst accepted
  logic                 w_empty;
  logic                 w_head;       // requester id at the FIFO head

  // Order FIFO: one requester-id bit per slot. Depth is a power of two,
  // so the pointers wrap by natural overflow.
  logic [C_MAX_OUTSTANDING-1:0] r_order;
  logic [C_PTR_W-1:0]           r_wr_ptr;
  logic [C_PTR_W-1:0]           r_rd_ptr;
  logic [C_CNT_W-1:0]           r_count;

`ifdef MCT_RD_ARB_ROUND_ROBIN_EN
  // Requester granted most recently. Resets to 1 so that requester 0
  // wins the first tie.
  logic r_rr_last;
`endif

  // --------------------------------------------------------------------------
  // Arbitration: a lone requester always wins; only a tie needs a policy.
  // --------------------------------------------------------------------------
  always_comb begin
    w_win = 1'b0;
    if (s0_arvalid && s1_arvalid) begin
`ifdef MCT_RD_ARB_ROUND_ROBIN_EN
      w_win = ~r_rr_last;
`else
      w_win = 1'b0;
`endif
    end else begin
      w_win = s1_arvalid;
    end
  end

  // Valid of the owning requester. It is only meaningful in ISSUE.
  assign w_sel_arvalid = r_sel ? s1_arvalid : s0_arvalid;
  assign w_ar_hs       = (r_state == ISSUE) && w_sel_arvalid && m_axi_arready;

  // --------------------------------------------------------------------------
  // AR FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_sel <= w_win;
      end
    end
  end

  // --------------------------------------------------------------------------
  // AR FSM: next state and AR-channel outputs.
  // The winner is registered first and issued one cycle later. This
  // keeps the request mux off the arbitration path. As a result, AR
  // handshakes are at least two cycles apart.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_grant       = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    s0_arready    = 1'b0;
    s1_arready    = 1'b0;
    case (r_state)
      ARB: begin
        if ((s0_arvalid || s1_arvalid) && (r_count < C_MAX_CNT)) begin
          w_grant     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        m_axi_arvalid = w_sel_arvalid;
        if (r_sel) begin
          m_axi_araddr = s1_araddr;
          m_axi_arlen  = s1_arlen;
          s1_arready   = m_axi_arready;
        end else begin
          m_axi_araddr = s0_araddr;
          m_axi_arlen  = s0_arlen;
          s0_arready   = m_axi_arready;
        end
        if (w_ar_hs) begin
          w_state_nxt = ARB;
        end
      end
      default: begin
        w_state_nxt = ARB;
      end
    endcase
  end

`ifdef MCT_RD_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last <= 1'b1;
    end else if (w_ar_hs) begin
      r_rr_last <= r_sel;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Order FIFO. A push happens on each AR handshake. A pop happens on
  // the last beat of the head burst. The grant is blocked when the FIFO
  // is full, so a push never meets a full FIFO. m_axi_rready is held low
  // when the FIFO is empty, so a pop never meets an empty FIFO.
  // --------------------------------------------------------------------------
  assign w_empty = (r_count == '0);
  assign w_head  = r_order[r_rd_ptr];
  assign w_pop   = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_order  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_order[r_wr_ptr] <= r_sel;
        r_wr_ptr          <= r_wr_ptr + C_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      end
      case ({w_ar_hs, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // R path: purely combinational steering by the FIFO head (no latency).
  // --------------------------------------------------------------------------
  always_comb begin
    m_axi_rready = 1'b0;
    s0_rvalid    = 1'b0;
    s1_rvalid    = 1'b0;
    if (!w_empty) begin
      if (w_head) begin
        s1_rvalid    = m_axi_rvalid;
        m_axi_rready = s1_rready;
      end else begin
        s0_rvalid    = m_axi_rvalid;
        m_axi_rready = s0_rready;
      end
    end
  end

  // Data and last are broadcast; only the routed rvalid qualifies them.
  assign s0_rdata = m_axi_rdata;
  assign s1_rdata = m_axi_rdata;
  assign s0_rlast = m_axi_rlast;
  assign s1_rlast = m_axi_rlast;

  assign outstanding = r_count;
  assign idle        = (r_state == ARB) && w_empty;

endmodule
`default_nettype wire

// File: tb/tb_mct_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mct_rd_arbiter
// Purpose  : Self-checking bench for mct_rd_arbiter. Requester models issue
//            bursts with addresses tagged by owner (0x1xxx / 0x2xxx). An
//            AXI slave model returns beats whose data is derived from the
//            address. At each requester AR handshake, expected beats are
//            pushed to a scoreboard. They are popped when the beat reaches
//            a requester. Grant order is checked against a queue of expected
//            owners. Build with MCT_RD_ARB_ROUND_ROBIN_EN to match an RR DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mct_rd_arbiter;

  localparam int AW = 64;
  localparam int DW = 512;
  localparam int NO = 8;
  localparam int CW = $clog2(NO + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
  logic          s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
  logic [AW-1:0] s0_araddr, s1_araddr, m_axi_araddr;
  logic [7:0]    s0_arlen, s1_arlen, m_axi_arlen;
  logic [DW-1:0] s0_rdata, s1_rdata, m_axi_rdata;
  logic          m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [CW-1:0] outstanding;
  logic          idle;

  always #5 clk = ~clk;

  mct_rd_arbiter #(
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_M_AXI_DATA_WIDTH (DW),
    .C_MAX_OUTSTANDING  (NO)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s0_arvalid    (s0_arvalid),
    .s0_arready    (s0_arready),
    .s0_araddr     (s0_araddr),
    .s0_arlen      (s0_arlen),
    .s0_rvalid     (s0_rvalid),
    .s0_rready     (s0_rready),
    .s0_rdata      (s0_rdata),
    .s0_rlast      (s0_rlast),
    .s1_arvalid    (s1_arvalid),
    .s1_arready    (s1_arready),
    .s1_araddr     (s1_araddr),
    .s1_arlen      (s1_arlen),
    .s1_rvalid     (s1_rvalid),
    .s1_rready     (s1_rready),
    .s1_rdata      (s1_rdata),
    .s1_rlast      (s1_rlast),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rlast   (m_axi_rlast),
    .outstanding   (outstanding),
    .idle          (idle)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- environment models ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } burst_t;
  typedef struct {
    bit            req;
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  int            remaining[2];
  logic [AW-1:0] next_addr[2];
  logic [7:0]    len_cfg[2];
  bit            rready_en[2];
  bit            arready_en, r_en;
  burst_t        bq[$];
  int            beat;
  beat_t         exp_q[$];
  bit            exp_grant[$];
  int            mdl_out, ar_cnt, pop_cnt;
  bit            saw_push, saw_pop;

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int b);
    logic [AW-1:0] w;
    w = a + AW'(b);
    return {8{w}};
  endfunction

  task automatic clear_models();
    remaining[0] = 0; remaining[1] = 0;
    rready_en[0] = 1'b0; rready_en[1] = 1'b0;
    arready_en = 1'b0; r_en = 1'b0;
    bq.delete(); exp_q.delete(); exp_grant.delete();
    beat = 0; mdl_out = 0;
  endtask

  task automatic drive();
    s0_arvalid    = remaining[0] > 0;
    s0_araddr     = next_addr[0];
    s0_arlen      = len_cfg[0];
    s1_arvalid    = remaining[1] > 0;
    s1_araddr     = next_addr[1];
    s1_arlen      = len_cfg[1];
    s0_rready     = rready_en[0];
    s1_rready     = rready_en[1];
    m_axi_arready = arready_en;
    if (r_en && bq.size() > 0) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = beat_data(bq[0].addr, beat);
      m_axi_rlast  = (beat == int'(bq[0].len));
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rdata  = '0;
      m_axi_rlast  = 1'b0;
    end
  endtask

  // Runs mid-cycle. The inputs are stable, so the handshakes seen here
  // are the ones that complete on the next rising edge.
  task automatic observe();
    bit    s_hs[2];
    bit    m_hs, mr_hs, s0r, s1r;
    beat_t e;
    saw_push = 1'b0;
    saw_pop  = 1'b0;
    check_val("outstanding", outstanding, mdl_out);
    if (outstanding == NO) check_val("full_no_arvalid", m_axi_arvalid, 0);
    check_val("rvalid_onehot", s0_rvalid & s1_rvalid, 0);

    s_hs[0] = s0_arvalid && s0_arready;
    s_hs[1] = s1_arvalid && s1_arready;
    m_hs    = m_axi_arvalid && m_axi_arready;
    check_val("ar_hs_match", m_hs, s_hs[0] | s_hs[1]);
    for (int r = 0; r < 2; r++) begin
      if (s_hs[r]) begin
        check_val("ar_addr", m_axi_araddr, next_addr[r]);
        check_val("ar_len", m_axi_arlen, len_cfg[r]);
        if (exp_grant.size() > 0) check_val("grant_order", r, exp_grant.pop_front());
        for (int b = 0; b <= int'(len_cfg[r]); b++)
          exp_q.push_back('{r[0], beat_data(next_addr[r], b), b == int'(len_cfg[r])});
        remaining[r]--;
        next_addr[r] += 64'h100;
        mdl_out++;
        ar_cnt++;
        saw_push = 1'b1;
      end
    end
    if (m_hs) bq.push_back('{m_axi_araddr, m_axi_arlen});

    mr_hs = m_axi_rvalid && m_axi_rready;
    s0r   = s0_rvalid && s0_rready;
    s1r   = s1_rvalid && s1_rready;
    check_val("r_hs_match", mr_hs, s0r | s1r);
    if (s0r || s1r) begin
      if (exp_q.size() == 0) begin
        check_val("r_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("r_owner", s1r, e.req);
        check_val("r_data", s1r ? s1_rdata : s0_rdata, e.data);
        check_val("r_last", s1r ? s1_rlast : s0_rlast, e.last);
      end
    end
    if (mr_hs) begin
      beat++;
      if (m_axi_rlast) begin
        void'(bq.pop_front());
        beat = 0;
        mdl_out--;
        pop_cnt++;
        saw_pop = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    observe();
  endtask

  task automatic wait_quiet(input int max, input string tag);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < max) begin
      step();
      n++;
      busy = (exp_q.size() > 0) || (remaining[0] > 0) || (remaining[1] > 0) || (mdl_out > 0);
    end
    check_val(tag, busy, 0);
  endtask

  // Reset is asserted mid-cycle, so the checks see the asynchronous effect.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_m_arvalid", m_axi_arvalid, 0);
    check_val("rst_arready", {s1_arready, s0_arready}, 0);
    check_val("rst_m_rready", m_axi_rready, 0);
    check_val("rst_rvalid", {s1_rvalid, s0_rvalid}, 0);
    check_val("rst_outstanding", outstanding, 0);
    check_val("rst_idle", idle, 1);
    clear_models();
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int ar0, p0, n;
    rst_n = 1'b1;
    next_addr[0] = 64'h1000; next_addr[1] = 64'h2000;
    len_cfg[0] = 8'd0; len_cfg[1] = 8'd0;
    ar_cnt = 0; pop_cnt = 0;
    clear_models();
    drive();
    do_reset();

    // single 4-beat burst from s0
    arready_en = 1'b1; r_en = 1'b1; rready_en[0] = 1'b1; rready_en[1] = 1'b1;
    len_cfg[0] = 8'd3; next_addr[0] = 64'h1000; remaining[0] = 1;
    step();
    check_val("t1_arb_no_arvalid", m_axi_arvalid, 0);
    step();
    check_val("t1_issue_arvalid", m_axi_arvalid, 1);
    step();
    check_val("t1_out1", outstanding, 1);
    check_val("t1_route_s0", {s1_rvalid, s0_rvalid}, 2'b01);
    wait_quiet(50, "t1_drain");
    step();
    check_val("t1_idle", idle, 1);

    // both request continuously
    do_reset();
    arready_en = 1'b1; r_en = 1'b1; rready_en[0] = 1'b1; rready_en[1] = 1'b1;
    len_cfg[0] = 8'd1; len_cfg[1] = 8'd1;
    next_addr[0] = 64'h1000; next_addr[1] = 64'h2000;
`ifdef MCT_RD_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 8; i++) exp_grant.push_back(i[0]);
`else
    for (int i = 0; i < 8; i++) exp_grant.push_back(i >= 4);
`endif
    remaining[0] = 4; remaining[1] = 4;
    wait_quiet(300, "t2_drain");
    check_val("t2_all_grants", exp_grant.size(), 0);

    // fill to the outstanding limit, then release with the first rlast
    arready_en = 1'b1; r_en = 1'b0; rready_en[0] = 1'b1; rready_en[1] = 1'b1;
    len_cfg[1] = 8'd1; next_addr[1] = 64'h2000; remaining[1] = 10;
    ar0 = ar_cnt;
    repeat (40) step();
    check_val("t3_ar8", ar_cnt - ar0, 8);
    check_val("t3_out8", outstanding, 8);
    check_val("t3_left2", remaining[1], 2);
    r_en = 1'b1;
    p0 = pop_cnt;
    n = 0;
    while (pop_cnt == p0 && n < 20) begin step(); n++; end
    check_val("t3_first_pop", pop_cnt - p0, 1);
    step();
    step();
    check_val("t3_regrant", ar_cnt - ar0, 9);
    wait_quiet(200, "t3_drain");
    check_val("t3_ar10", ar_cnt - ar0, 10);

    // push and pop in the same cycle at outstanding 3
    arready_en = 1'b1; r_en = 1'b0;
    len_cfg[0] = 8'd0; next_addr[0] = 64'h1400; remaining[0] = 3;
    repeat (12) step();
    check_val("t4_out3", outstanding, 3);
    arready_en = 1'b0;
    len_cfg[1] = 8'd0; next_addr[1] = 64'h2400; remaining[1] = 1;
    n = 0;
    while (!m_axi_arvalid && n < 10) begin step(); n++; end
    check_val("t4_issue_stall", m_axi_arvalid, 1);
    arready_en = 1'b1; r_en = 1'b1;
    step();
    check_val("t4_push_pop", {saw_push, saw_pop}, 2'b11);
    @(posedge clk);
    #1;
    check_val("t4_out_kept", outstanding, 3);
    wait_quiet(100, "t4_drain");

    // head is s1 and s1 is not ready
    arready_en = 1'b1; r_en = 1'b0; rready_en[1] = 1'b0;
    len_cfg[1] = 8'd1; next_addr[1] = 64'h2800; remaining[1] = 1;
    repeat (4) step();
    r_en = 1'b1;
    repeat (3) step();
    check_val("t5_m_rready", m_axi_rready, 0);
    check_val("t5_s0_rvalid", s0_rvalid, 0);
    check_val("t5_s1_rvalid", s1_rvalid, 1);
    rready_en[1] = 1'b1;
    wait_quiet(50, "t5_drain");

    // reset in the middle of traffic
    arready_en = 1'b1; r_en = 1'b0; rready_en[0] = 1'b1; rready_en[1] = 1'b1;
    len_cfg[0] = 8'd3; next_addr[0] = 64'h1800; remaining[0] = 2;
    repeat (8) step();
    check_val("t6_out2", outstanding, 2);
    arready_en = 1'b0; r_en = 1'b1;
    len_cfg[1] = 8'd0; next_addr[1] = 64'h2C00; remaining[1] = 1;
    step();
    step();
    check_val("t6_pre_arvalid", m_axi_arvalid, 1);
    check_val("t6_pre_rready", m_axi_rready, 1);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mct_rd_arbiter.md
MCT_RD_ARBITER -- requirements
Module: mct_rd_arbiter

Interface
REQ-001 The block SHALL expose parameter C_M_AXI_ADDR_WIDTH, default 64, meaning the read address width.
REQ-002 The block SHALL expose parameter C_M_AXI_DATA_WIDTH, default 512, meaning the read data width.
REQ-003 The block SHALL expose parameter C_MAX_OUTSTANDING, default 8, meaning the maximum number of granted, uncompleted bursts; it is a power of 2, ≥2.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Ports s0_arvalid/s0_arready, input/output, 1 bit each: requester 0 AR handshake.
REQ-008 Ports s0_araddr/s0_arlen, input, ADDR/8 bits: requester 0 burst address and length.
REQ-009 Ports s0_rvalid/s0_rready, output/input, 1 bit each: requester 0 R handshake.
REQ-010 Ports s0_rdata/s0_rlast, output, DATA/1 bits: requester 0 read data and last-beat flag.
REQ-011 Ports s1_* SHALL be identical to s0_* and belong to requester 1.
REQ-012 Ports m_axi_arvalid/arready/araddr/arlen and m_axi_rvalid/rready/rdata/rlast SHALL form the shared AXI4 read master, with AXI directions and the widths above.
REQ-013 Port outstanding, output, $clog2(C_MAX_OUTSTANDING+1) bits: current order-FIFO occupancy.
REQ-014 Port idle, output, 1 bit: high when the FSM is ARB and outstanding==0.

Function
REQ-015 The AR FSM SHALL have two states, ARB and ISSUE; the reset state is ARB.
REQ-016 In ARB, if any sX_arvalid is high and outstanding<C_MAX_OUTSTANDING, the FSM SHALL register a winner in sel and move to ISSUE on the next edge; otherwise it SHALL stay in ARB.
REQ-017 In ARB, m_axi_arvalid, s0_arready and s1_arready SHALL be 0.
REQ-018 In ISSUE, m_axi_arvalid/araddr/arlen SHALL be combinationally muxed from requester sel, and s<sel>_arready SHALL equal m_axi_arready; the other requester's arready SHALL be 0.
REQ-019 On the ISSUE AR handshake, the FSM SHALL push sel into the order FIFO and return to ARB; the minimum spacing between AR handshakes is 2 cycles.
REQ-020 A requester SHALL hold arvalid and its payload stable until its handshake completes; the block does not re-arbitrate while in ISSUE.
REQ-021 When the order FIFO is empty: m_axi_rready=0, s0_rvalid=0, s1_rvalid=0.
REQ-022 When non-empty with head h: s<h>_rvalid=m_axi_rvalid, m_axi_rready=s<h>_rready, the other sX_rvalid=0; rdata and rlast SHALL be broadcast to both requesters.
REQ-023 A beat with m_axi_rvalid&m_axi_rready&m_axi_rlast SHALL pop the FIFO head.
REQ-024 A push and a pop in the same cycle SHALL leave outstanding unchanged; the FIFO pointers SHALL wrap modulo C_MAX_OUTSTANDING.
REQ-025 Arbitration SHALL never grant at outstanding==C_MAX_OUTSTANDING, so the FIFO never overflows; a pop cannot occur when the FIFO is empty (REQ-021).
REQ-026 Bursts SHALL return in AR-issue order (single AXI ID); the R path SHALL add zero cycles of latency.

Reset
REQ-027 While rst_n is low, the block SHALL be in state ARB with sel=0, FIFO pointers and count=0, and rr_last=1, so that requester 0 wins the first round-robin tie.
REQ-028 During reset, all valid/ready outputs SHALL be 0, outstanding SHALL be 0 and idle SHALL be 1.
REQ-029 Asserting reset mid-burst SHALL discard the in-flight routing state; the system SHALL reset the shared AXI slave at the same time.

Configuration
REQ-030 Macro MCT_RD_ARB_ROUND_ROBIN_EN defined: on a tie, the winner SHALL be the requester not granted last (rr_last updates on each AR handshake).
REQ-031 Macro MCT_RD_ARB_ROUND_ROBIN_EN undefined: fixed priority SHALL apply, requester 0 always winning a tie, and rr_last is not implemented.

Verification
REQ-032 Scenario: after reset, s0 requests addr 0x1000 len 3, arready=1 -> m_axi_arvalid rises 1 cycle later, then 4 beats route to s0 only, outstanding goes 1->0, idle=1.
REQ-033 Scenario: s0 and s1 request continuously, 4 bursts, RR on -> grant order 0,1,0,1; RR off -> 0,0,0,0 while s0 still requests.
REQ-034 Scenario: arready=1, rvalid=0, 10 requests from s1 -> exactly 8 AR handshakes, outstanding=8, no arvalid in ARB while full; the first rlast re-enables a grant.
REQ-035 Scenario: at outstanding=3, push and rlast-pop in the same cycle -> outstanding stays 3 and the head advances.
REQ-036 Scenario: head=s1 with s1_rready=0 -> m_axi_rready=0 and s0_rvalid=0 until s1_rready rises.
REQ-037 Scenario: rst_n asserted low mid-burst at outstanding=2 -> all outputs take the REQ-028 values asynchronously.
